game_state_ctrl: RTL
====================

# game_state_ctrl

Game-level sequencer for Frogger, upstream of `frogger_game`. It debounces the start button and runs the IDLE/RUNNING/P1_WINS/CLEANUP state machine. It tracks lives from collision events and detects goal-row arrival. It drives `o_Game_Active`, lives and one-cycle respawn/clear pulses consumed by `frogger_ctrl`, the renderer and `score_control`.

## Interface
Parameters:
- `c_LIVES`, 3: lives loaded at reset and on every new game; legal range 1..3.
- `c_GOAL_ROW`, 0: frog tile row that counts as a win.
- `c_DEBOUNCE`, 250000: cycles the synchronized button must be stable before its debounced value changes.
- `c_GRACE`, 12500000: cycles after a hit during which collisions are ignored.
- `c_WIN_HOLD`, 75000000: cycles spent in P1_WINS before CLEANUP.

Ports:
- `i_Clk`  in  1: system clock. One clock domain only.
- `i_Rst`  in  1: reset, synchronous, active-high.
- `i_Game_Start`  in  1: raw start button, active-high, asynchronous to `i_Clk`.
- `i_Collided`  in  1: level from `frogger_collisions`, frog overlaps a car.
- `i_Frogger_Y`  in  6: frog tile row.
- `o_Game_Active`  out  1: high only in RUNNING.
- `o_State`  out  2: 00 IDLE, 01 RUNNING, 10 P1_WINS, 11 CLEANUP.
- `o_Lives`  out  2: remaining lives.
- `o_Frog_Respawn`  out  1: one-cycle pulse; return frog to origin.
- `o_Score_Clear`  out  1: one-cycle pulse; clear score.
- `o_Round_Win`  out  1: one-cycle pulse on entering P1_WINS.

## Operation
- **Button input chain**
  - 2-flop synchronizer on `i_Game_Start`.
  - Debounce counter resets on every synchronized change.
  - When the counter reaches `c_DEBOUNCE`, the debounced value takes the synchronized value.
  - Start pulse = rising edge of the debounced value.
- **Collision edge detect:** `hit` = `i_Collided` & ~previous `i_Collided` & (grace counter == 0).
- **Goal detect:** `goal` = (`i_Frogger_Y` == `c_GOAL_ROW`).
- **IDLE**
  - Start pulse -> RUNNING. Assert `o_Frog_Respawn` and `o_Score_Clear` for that one cycle.
  - Lives are held at `c_LIVES`.
- **RUNNING**
  - Priority: hit > goal. A hit and a goal in the same cycle resolve as the hit.
  - hit with lives > 1: decrement lives, pulse `o_Frog_Respawn`, load grace counter with `c_GRACE`, stay in RUNNING.
  - hit with lives == 1: lives -> 0, go to CLEANUP.
  - goal (no hit): go to P1_WINS, pulse `o_Round_Win`, load hold counter with `c_WIN_HOLD`.
  - Start pulses are ignored.
- **P1_WINS**
  - Hold counter decrements each cycle. When it reaches 0 -> CLEANUP.
  - Collisions and start pulses are ignored.
- **CLEANUP** (exactly one cycle)
  - Pulse `o_Frog_Respawn`, reload lives to `c_LIVES`, clear grace and hold counters, go to IDLE.
- **Grace counter:** decrements to 0 and saturates there. It only runs in RUNNING.
- **Width rules**
  - Lives never wrap below 0.
  - Counters are sized as clog2(parameter+1).
  - Comparisons are unsigned.

## Timing
- **Reset values** (cycle after `i_Rst` is sampled high):
  - State IDLE, `o_State`=00, `o_Game_Active`=0, `o_Lives`=`c_LIVES`.
  - All pulse outputs 0; synchronizer, debounced value and all counters 0.
- **Reset mid-game:** takes priority over every transition, in any state, with the same values. A pulse in flight is killed.
- **Registered outputs:** all outputs are registered. `o_Game_Active` is decoded from the state register, so it changes in the same cycle as `o_State`.
- **Collision latency:** a `hit` sampled at edge N gives new state, lives and pulses visible after edge N+1.
- **Button latency:** a clean button press becomes visible as RUNNING c_DEBOUNCE+4 cycles after the raw rising edge (±1).
- **Held button:** a button held through reset yields one start after debounce. A held button never retriggers; it must be released and pressed again.
- **Pulse width:** every pulse is exactly one cycle wide, including back-to-back hits separated by `c_GRACE`.

## Test plan
Bench parameters: `c_LIVES`=3, `c_DEBOUNCE`=4, `c_GRACE`=5, `c_WIN_HOLD`=10, `c_GOAL_ROW`=0.

1. **Start debounce**
   - Stimulus: raw start high for 3 cycles, then low, then high for 10 cycles.
   - Required: no start from the 3-cycle glitch. From the 10-cycle press, exactly one transition IDLE->RUNNING, with `o_Score_Clear`=`o_Frog_Respawn`=1 for one cycle.
2. **Lives countdown**
   - Stimulus: in RUNNING, 1-cycle `i_Collided` pulses spaced 8 cycles apart.
   - Required: lives 3->2->1. `o_Frog_Respawn` pulses twice. The third hit gives CLEANUP (lives 0) for one cycle, then IDLE with lives 3.
3. **Grace window**
   - Stimulus: a hit, then `i_Collided` toggling again 2 cycles later.
   - Required: lives stay at 2, no pulse. A hit 6 cycles after the first decrements to 1.
4. **Win**
   - Stimulus: `i_Frogger_Y`=0 in RUNNING.
   - Required: `o_Round_Win` pulse, state 10 for 10 cycles, then 11 for 1 cycle, then 00. Start presses during P1_WINS are ignored.
5. **Simultaneous hit and goal**
   - Stimulus: hit and Y=0 on the same cycle with lives 2.
   - Required: lives 1, state stays RUNNING, no `o_Round_Win`.
6. **Reset mid-game**
   - Stimulus: `i_Rst` during P1_WINS with counter at 5.
   - Required: next cycle state 00, lives 3, all pulses 0, no later CLEANUP.

Source files
------------

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: game-level sequencer for Frogger.
// Debounces the start button, counts lives from collision edges and detects
// arrival on the goal row. Runs the IDLE/RUNNING/P1_WINS/CLEANUP state machine
// and emits registered one-cycle respawn/clear/win pulses.
// The current FSM state is always visible on o_State.
module game_state_ctrl #(
  parameter int unsigned c_LIVES    = 3,
  parameter int unsigned c_GOAL_ROW = 0,
  parameter int unsigned c_DEBOUNCE = 250000,
  parameter int unsigned c_GRACE    = 12500000,
  parameter int unsigned c_WIN_HOLD = 75000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Game_Start,
  input  logic       i_Collided,
  input  logic [5:0] i_Frogger_Y,
  output logic       o_Game_Active,
  output logic [1:0] o_State,
  output logic [1:0] o_Lives,
  output logic       o_Frog_Respawn,
  output logic       o_Score_Clear,
  output logic       o_Round_Win
);

  localparam int unsigned DB_W    = (c_DEBOUNCE > 0) ? $clog2(c_DEBOUNCE + 1) : 1;
  localparam int unsigned GRACE_W = (c_GRACE > 0)    ? $clog2(c_GRACE + 1)    : 1;
  localparam int unsigned HOLD_W  = (c_WIN_HOLD > 0) ? $clog2(c_WIN_HOLD + 1) : 1;

  localparam logic [DB_W-1:0]    DB_MAX     = DB_W'(c_DEBOUNCE);
  localparam logic [GRACE_W-1:0] GRACE_LOAD = GRACE_W'(c_GRACE);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(c_WIN_HOLD);
  localparam logic [1:0]         LIVES_INIT = 2'(c_LIVES);
  localparam logic [5:0]         GOAL_ROW   = 6'(c_GOAL_ROW);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_P1_WINS = 2'b10,
    ST_CLEANUP = 2'b11
  } state_e;

  // Button chain: two synchronizer stages plus one history stage for change detection.
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            sync3_q, sync3_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            db_q, db_d;
  logic            db_prev_q, db_prev_d;
  logic            start_pulse;

  // Collision edge and goal are registered so hit and goal align in the same cycle.
  logic coll_q, coll_d;
  logic coll_prev_q, coll_prev_d;
  logic goal_q, goal_d;
  logic hit;

  state_e               state_q, state_d;
  logic [1:0]           lives_q, lives_d;
  logic [GRACE_W-1:0]   grace_q, grace_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 respawn_q, respawn_d;
  logic                 clear_q, clear_d;
  logic                 win_q, win_d;

  // Synchronize and debounce the raw start button; debounced value follows a stable input.
  always_comb begin
    sync1_d   = i_Game_Start;
    sync2_d   = sync1_q;
    sync3_d   = sync2_q;
    db_cnt_d  = db_cnt_q;
    db_d      = db_q;
    db_prev_d = db_q;
    if (sync2_q != sync3_q) begin
      db_cnt_d = '0;
    end else if (sync2_q == db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_MAX) begin
      db_d     = sync2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  assign start_pulse = db_q & ~db_prev_q;

  // Register collision level/history and goal-row match.
  always_comb begin
    coll_d      = i_Collided;
    coll_prev_d = coll_q;
    goal_d      = (i_Frogger_Y == GOAL_ROW);
  end

  assign hit = coll_q & ~coll_prev_q & (grace_q == '0);

  // Next-state, lives, counters and pulse generation.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    grace_d   = grace_q;
    hold_d    = hold_q;
    respawn_d = 1'b0;
    clear_d   = 1'b0;
    win_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        lives_d = LIVES_INIT;
        if (start_pulse) begin
          state_d   = ST_RUNNING;
          respawn_d = 1'b1;
          clear_d   = 1'b1;
        end
      end
      ST_RUNNING: begin
        if (grace_q != '0) grace_d = grace_q - 1'b1;
        if (hit) begin
          if (lives_q > 2'd1) begin
            lives_d   = lives_q - 2'd1;
            respawn_d = 1'b1;
            grace_d   = GRACE_LOAD;
          end else begin
            lives_d = 2'd0;
            state_d = ST_CLEANUP;
          end
        end else if (goal_q) begin
          state_d = ST_P1_WINS;
          win_d   = 1'b1;
          hold_d  = HOLD_LOAD;
        end
      end
      ST_P1_WINS: begin
        // Leaving when the count would hit zero keeps P1_WINS exactly c_WIN_HOLD cycles.
        if (hold_q <= HOLD_W'(1)) begin
          hold_d  = '0;
          state_d = ST_CLEANUP;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      ST_CLEANUP: begin
        respawn_d = 1'b1;
        lives_d   = LIVES_INIT;
        grace_d   = '0;
        hold_d    = '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset wins over every transition.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      db_cnt_q    <= '0;
      db_q        <= 1'b0;
      db_prev_q   <= 1'b0;
      coll_q      <= 1'b0;
      coll_prev_q <= 1'b0;
      goal_q      <= 1'b0;
      state_q     <= ST_IDLE;
      lives_q     <= LIVES_INIT;
      grace_q     <= '0;
      hold_q      <= '0;
      respawn_q   <= 1'b0;
      clear_q     <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      db_cnt_q    <= db_cnt_d;
      db_q        <= db_d;
      db_prev_q   <= db_prev_d;
      coll_q      <= coll_d;
      coll_prev_q <= coll_prev_d;
      goal_q      <= goal_d;
      state_q     <= state_d;
      lives_q     <= lives_d;
      grace_q     <= grace_d;
      hold_q      <= hold_d;
      respawn_q   <= respawn_d;
      clear_q     <= clear_d;
      win_q       <= win_d;
    end
  end

  assign o_State        = state_q;
  assign o_Game_Active  = (state_q == ST_RUNNING);
  assign o_Lives        = lives_q;
  assign o_Frog_Respawn = respawn_q;
  assign o_Score_Clear  = clear_q;
  assign o_Round_Win    = win_q;

endmodule
